// File: rtl/score_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : score_seg_scan
// Purpose  : Reads the 16-bit game score, converts it to four BCD digits with
//            a sequential double-dabble engine and time-multiplexes them onto
//            a 4-digit common-anode seven-segment display. Blinks while the
//            fail flag is asserted.
// Revision : 1.0  initial release
// ============================================================================
module score_seg_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score,
    input  logic        fail,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  AN
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  c_scan_last  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK_DIV - 1);

    localparam logic [15:0] c_score_max = 16'd9999;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    localparam logic [6:0] c_seg_off = 7'h7F;
    localparam logic [3:0] c_an_off  = 4'hF;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [15:0]        r_score_q;
    logic [15:0]        r_bin;
    logic [15:0]        r_bcd;
    logic [3:0]         r_iter;
    logic [15:0]        r_disp;

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]         r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;

    logic [15:0]        w_conv_in;
    logic [15:0]        w_bcd_adj;
    logic [6:0]         w_dig_seg [4];
    logic [3:0]         w_blank;
    logic               w_off;
    logic [6:0]         w_seg_next;
    logic [3:0]         w_an_next;
    logic               w_dp_next;

    // Scores above the four-digit range saturate to 9999
    assign w_conv_in = (score > c_score_max) ? c_score_max : score;

    // Double-dabble correction: each BCD nibble >= 5 gets +3 before the shift
    generate
        for (genvar i = 0; i < 4; i++) begin : g_adj
            assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5)
                                         ? (r_bcd[4*i +: 4] + 4'd3)
                                         : r_bcd[4*i +: 4];
        end
    endgenerate

    // Segment pattern for every displayed digit
    generate
        for (genvar i = 0; i < 4; i++) begin : g_dec
            assign w_dig_seg[i] = seg_decode(r_disp[4*i +: 4]);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Conversion FSM: capture on score change, 16 shift iterations, then an
    // atomic load of all four digits into the display register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_score_q <= 16'd0;
            r_bin     <= 16'd0;
            r_bcd     <= 16'd0;
            r_iter    <= 4'd0;
            r_disp    <= 16'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (score != r_score_q) begin
                        r_bin     <= w_conv_in;
                        r_score_q <= score;
                        r_bcd     <= 16'd0;
                        r_iter    <= 4'd0;
                        r_state   <= c_shift;
                    end
                end
                c_shift: begin
                    r_bcd  <= {w_bcd_adj[14:0], r_bin[15]};
                    r_bin  <= {r_bin[14:0], 1'b0};
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == 4'd15) begin
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    r_disp  <= r_bcd;
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // Digit-slot timer and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (r_scan_cnt == c_scan_last) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Blink timer: runs only while fail is high, otherwise parked in the on phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (!fail) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Leading-zero blanking, blink masking and next output values
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = (r_disp[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (r_disp[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (r_disp[7:4]  == 4'd0);
        w_blank[0] = 1'b0;

        w_off      = fail && !r_phase;

        w_seg_next = w_dig_seg[r_idx];
        w_an_next  = ~(4'b0001 << r_idx);
        if (w_off || w_blank[r_idx]) begin
            w_seg_next = c_seg_off;
            w_an_next  = c_an_off;
        end

        w_dp_next  = !(fail && r_phase && (r_idx == 2'd0));
    end

    // Registered display drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= c_seg_off;
            AN  <= c_an_off;
            dp  <= 1'b1;
        end else begin
            seg <= w_seg_next;
            AN  <= w_an_next;
            dp  <= w_dp_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_score_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_seg_scan
// Purpose  : Self-checking bench for score_seg_scan with a decimal-level
//            reference model and randomized score/fail/reset stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_score_seg_scan;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 64;

    logic        clk;
    logic        rst;
    logic [15:0] score;
    logic        fail;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  AN;

    int n_pass;
    int n_total;
    bit run_chk;

    score_seg_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .score (score),
        .fail  (fail),
        .seg   (seg),
        .dp    (dp),
        .AN    (AN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: decimal value shown, slot/blink timers, conversion
    // modelled as "value appears 17 edges after the change is seen, busy
    // meanwhile".
    // ------------------------------------------------------------------------
    int         m_disp, m_scoreq, m_pend, m_left;
    bit         m_busy;
    int         m_scan, m_idx, m_blink;
    bit         m_phase;
    logic [11:0] e_out;

    function automatic logic [6:0] digit_seg(input int d);
        logic [6:0] tab [10];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tab[d];
    endfunction

    // Expected {seg, AN, dp} for a given slot, decimal value, fail and phase
    function automatic logic [11:0] exp_out(input int idx, input int disp,
                                            input logic f, input bit ph);
        int         pw [4];
        logic [6:0] s;
        logic [3:0] a;
        logic       d;
        pw = '{1, 10, 100, 1000};
        s = digit_seg((disp / pw[idx]) % 10);
        a = 4'hF;
        a[idx] = 1'b0;
        if ((f && !ph) || (idx > 0 && disp < pw[idx])) begin
            s = 7'h7F;
            a = 4'hF;
        end
        d = !(f && ph && idx == 0);
        return {s, a, d};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_disp  <= 0;
            m_scoreq <= 0;
            m_pend  <= 0;
            m_left  <= 0;
            m_busy  <= 1'b0;
            m_scan  <= 0;
            m_idx   <= 0;
            m_blink <= 0;
            m_phase <= 1'b1;
            e_out   <= {7'h7F, 4'hF, 1'b1};
        end else begin
            e_out <= exp_out(m_idx, m_disp, fail, m_phase);
            if (m_scan == SCAN_DIV - 1) begin
                m_scan <= 0;
                m_idx  <= (m_idx + 1) % 4;
            end else begin
                m_scan <= m_scan + 1;
            end
            if (!fail) begin
                m_blink <= 0;
                m_phase <= 1'b1;
            end else if (m_blink == BLINK_DIV - 1) begin
                m_blink <= 0;
                m_phase <= !m_phase;
            end else begin
                m_blink <= m_blink + 1;
            end
            if (m_busy) begin
                if (m_left == 1) begin
                    m_disp <= m_pend;
                    m_busy <= 1'b0;
                end
                m_left <= m_left - 1;
            end else if (int'(score) != m_scoreq) begin
                m_scoreq <= int'(score);
                m_pend   <= (score > 16'd9999) ? 9999 : int'(score);
                m_busy   <= 1'b1;
                m_left   <= 17;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (run_chk) begin
            check("cycle_out", {20'd0, seg, AN, dp}, {20'd0, e_out});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Record the segment pattern seen in each digit slot over n cycles
    logic [6:0] seen [4];
    bit         odd_an;
    task automatic collect(input int n);
        for (int k = 0; k < 4; k++) seen[k] = 7'h7F;
        odd_an = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
            case (AN)
                4'hE: seen[0] = seg;
                4'hD: seen[1] = seg;
                4'hB: seen[2] = seg;
                4'h7: seen[3] = seg;
                4'hF: ;
                default: odd_an = 1'b1;
            endcase
        end
    endtask

    initial begin
        int r;
        rst = 1'b1;
        score = 16'd0;
        fail = 1'b0;
        n_pass = 0;
        n_total = 0;
        run_chk = 1'b0;
        repeat (3) @(negedge clk);
        run_chk = 1'b1;
        #2;
        check("reset_out", {20'd0, seg, AN, dp}, {20'd0, 7'h7F, 4'hF, 1'b1});
        step(1);
        rst = 1'b0;

        // Zero score: only the rightmost digit lit, showing 0
        step(4);
        collect(16);
        check("zero_d0", {25'd0, seen[0]}, 32'h40);
        check("zero_d1_blank", {25'd0, seen[1]}, 32'h7F);

        // 1234 with latency pin on the model
        score = 16'd1234;
        repeat (17) @(posedge clk);
        #1;
        check("model_lat_before", m_disp, 0);
        @(posedge clk);
        #1;
        check("model_lat_at", m_disp, 1234);
        step(4);
        collect(16);
        check("d1234_an0", {25'd0, seen[0]}, 32'h19);
        check("d1234_an1", {25'd0, seen[1]}, 32'h30);
        check("d1234_an2", {25'd0, seen[2]}, 32'h24);
        check("d1234_an3", {25'd0, seen[3]}, 32'h79);

        // Saturation
        score = 16'hFFFF;
        step(40);
        collect(16);
        check("sat_an0", {25'd0, seen[0]}, 32'h10);
        check("sat_an3", {25'd0, seen[3]}, 32'h10);

        // Single digit
        score = 16'd7;
        step(40);
        collect(16);
        check("seven_an0", {25'd0, seen[0]}, 32'h78);
        check("seven_blank", {24'd0, seen[1] & seen[2] & seen[3], odd_an}, {24'd0, 7'h7F, 1'b0});

        // Change during an in-flight conversion
        score = 16'd50;
        step(3);
        score = 16'd60;
        step(40);
        collect(16);
        check("d60_an1", {25'd0, seen[1]}, 32'h02);

        // Blink with 42
        score = 16'd42;
        step(30);
        fail = 1'b1;
        step(70);
        check("blink_off", {27'd0, AN, dp}, {27'd0, 4'hF, 1'b1});
        step(100);
        fail = 1'b0;
        step(20);

        // Reset in the middle of a conversion
        score = 16'd999;
        step(5);
        rst = 1'b1;
        #1;
        check("midrst_out", {20'd0, seg, AN, dp}, {20'd0, 7'h7F, 4'hF, 1'b1});
        step(1);
        rst = 1'b0;
        step(40);
        collect(16);
        check("d999_an2", {25'd0, seen[2]}, 32'h10);
        check("d999_an3", {25'd0, seen[3]}, 32'h7F);

        // Randomized score/fail/reset traffic
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                if ($urandom_range(0, 4) == 0) score = 16'($urandom);
                else score = 16'($urandom_range(0, 9999));
            end else if (r < 70) begin
                fail = !fail;
            end else if (r < 74) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
            step($urandom_range(1, 30));
        end

        step(10);
        run_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_seg_scan.md
Name: score_seg_scan

Overview:
- Reader side of the game-state `score` bus driven by the game controller.
- Converts the 16-bit binary score to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto the board's 4-digit common-anode seven-segment display.
- Blinks the display while `fail` is asserted; otherwise holds a stable decimal readout.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz digit rate at 100 MHz); minimum 2.
- BLINK_DIV, 25000000: clk cycles per blink half-period while fail=1 (2 Hz blink at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-high
- score  input  16  unsigned binary score from the controller; synchronous to clk
- fail  input  1  game-over flag from the controller
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- dp  output  1  decimal point, active-low, registered
- AN  output  4  digit enables, active-low; AN[0] is the rightmost digit; registered

Behaviour:
- Reset (asynchronous, while rst=1):
  - seg=7'h7F, dp=1, AN=4'hF.
  - Display register holds BCD 0000; last-converted register score_q=0.
  - FSM in IDLE; scan counter, digit index and blink counter all 0; blink phase = on.
- Clamp: conv_in = (score > 9999) ? 9999 : score, evaluated when a conversion starts.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE:
    - If score != score_q, capture conv_in into the shift register and score into score_q, clear the 16-bit BCD accumulator, set iteration count 0, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT, one iteration per cycle:
    - Add 3 to every BCD nibble that is >= 5.
    - Then shift {bcd, bin} left by 1.
    - After 16 iterations go to DONE.
  - DONE: load the BCD accumulator into the display register in one cycle (atomic update of all four digits), go to IDLE.
  - Latency: score change to display-register update is 18 cycles from the first clk edge that samples the new score.
  - Score change during SHIFT/DONE: the in-flight conversion completes with the old value. IDLE then sees score != score_q and starts a new conversion. There is no abort, so the display never shows a mixed value.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1.
  - On wrap, digit index increments 0,1,2,3,0 (2-bit, natural wrap).
  - Outputs are registered from the digit index plus the display register; they change one cycle after the index changes.
- Segment decode, standard active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Nibbles >9 are unreachable; they decode to 7'h7F.
- Leading-zero blanking:
  - Digit k (k=1..3) is blanked when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - A blanked slot drives AN=4'hF and seg=7'h7F.
- Active slot: AN has exactly one bit low, at the current index.
- Blink:
  - While fail=1, the blink counter counts 0..BLINK_DIV-1 and toggles the phase on wrap.
  - Off phase forces AN=4'hF, seg=7'h7F, dp=1.
  - When fail=0, the blink counter is held at 0 and the phase is held on.
  - A fail 1->0 transition restores display from the next cycle.
- dp:
  - Low only when fail=1, the phase is on, and the active slot is digit 0.
  - High in all other cases.
- Reset mid-conversion or mid-scan: immediate return to the reset values above. After release, display shows "0" on AN[0] until a nonzero score is converted.
- No combinational path from inputs to outputs.

Test Plan (SCAN_DIV=4, BLINK_DIV=64 for simulation):
- Reset, score=0, fail=0 -> AN cycles through 4'hE with seg=7'h40; AN[3:1] stay high (blanked); dp=1 throughout.
- score 0->1234 at cycle t -> display register =1234 at t+18; scan shows AN 4'hE/4'hD/4'hB/4'h7 with seg 7'h19/7'h30/7'h24/7'h79.
- score=65535 -> shows 9999 (every slot seg=7'h10); score=7 -> only AN[0] ever goes low, seg=7'h78.
- score 50->60 three cycles into a conversion -> display shows 50 after the first DONE, then 60 exactly 18 cycles after that DONE, with no intermediate value.
- fail=1 with score=42 -> AN forced 4'hF for 64 cycles alternating with 64 cycles of normal scan; dp=0 only while AN=4'hE in the on phase; fail=0 restores the steady display next cycle.
- rst pulsed mid-SHIFT with score=999 -> outputs immediately seg=7'h7F, AN=4'hF, dp=1; after release a fresh conversion yields 999 in 18 cycles.
